// File: rtl/tex_mem_responder_pkg.sv
// Shared constants and response type for the texture memory responder and its memory-path benches.
package tex_mem_responder_pkg;

  localparam int TEX_MEM_NUM_REQS_DEFAULT   = 4;
  localparam int TEX_MEM_ADDR_WIDTH_DEFAULT = 12;
  localparam int TEX_MEM_TAG_WIDTH_DEFAULT  = 8;
  localparam int TEX_MEM_LATENCY_DEFAULT    = 2;
  localparam int TEX_MEM_RSP_QUEUE_DEFAULT  = 4;
  localparam int TEX_MEM_DATA_W             = 32;

  typedef struct packed {
    logic [TEX_MEM_TAG_WIDTH_DEFAULT-1:0] tag;
    logic [TEX_MEM_DATA_W-1:0]            data;
  } tex_mem_rsp_t;

endpackage

// File: rtl/tex_mem_responder_if.sv
// Multi-channel word request/response bus between texture cache requesters and the memory responder.
interface tex_mem_responder_if
  import tex_mem_responder_pkg::*;
#(
  parameter int NUM_REQS   = TEX_MEM_NUM_REQS_DEFAULT,
  parameter int ADDR_WIDTH = TEX_MEM_ADDR_WIDTH_DEFAULT,
  parameter int TAG_WIDTH  = TEX_MEM_TAG_WIDTH_DEFAULT
);
  logic [NUM_REQS-1:0]                req_valid;
  logic [NUM_REQS-1:0]                req_rw;
  logic [NUM_REQS*4-1:0]              req_byteen;
  logic [NUM_REQS*ADDR_WIDTH-1:0]     req_addr;
  logic [NUM_REQS*TEX_MEM_DATA_W-1:0] req_data;
  logic [NUM_REQS*TAG_WIDTH-1:0]      req_tag;
  logic [NUM_REQS-1:0]                req_ready;
  logic [NUM_REQS-1:0]                rsp_valid;
  logic [NUM_REQS*TEX_MEM_DATA_W-1:0] rsp_data;
  logic [NUM_REQS*TAG_WIDTH-1:0]      rsp_tag;
  logic [NUM_REQS-1:0]                rsp_ready;

  modport master (
    output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/tex_mem_responder_rsp_lane.sv
// One response channel: FIFO of returning reads plus the credit counter that bounds outstanding reads.
module tex_mem_rsp_lane
  import tex_mem_responder_pkg::*;
#(
  parameter int TAG_WIDTH = TEX_MEM_TAG_WIDTH_DEFAULT,
  parameter int RSP_QUEUE = TEX_MEM_RSP_QUEUE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      take,
  input  logic                      push,
  input  logic [TAG_WIDTH-1:0]      push_tag,
  input  logic [TEX_MEM_DATA_W-1:0] push_data,
  output logic                      credit_avail,
  output logic                      rsp_valid,
  output logic [TAG_WIDTH-1:0]      rsp_tag,
  output logic [TEX_MEM_DATA_W-1:0] rsp_data,
  input  logic                      rsp_ready
);
  localparam int PW = $clog2(RSP_QUEUE);
  localparam int CW = PW + 1;

  logic [TAG_WIDTH-1:0]      tag_q  [RSP_QUEUE];
  logic [TEX_MEM_DATA_W-1:0] data_q [RSP_QUEUE];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count, credits;
  logic                      pop;

  assign pop          = rsp_valid && rsp_ready;
  assign rsp_valid    = (count != '0);
  assign rsp_tag      = tag_q[rd_ptr];
  assign rsp_data     = data_q[rd_ptr];
  assign credit_avail = (credits != '0);

  // Credits cover both the read pipeline and the queue, so a push can never find the queue full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= CW'(RSP_QUEUE);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count + CW'(push) - CW'(pop);
      credits <= credits - CW'(take) + CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[wr_ptr]  <= push_tag;
      data_q[wr_ptr] <= push_data;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && count == CW'(RSP_QUEUE)));
  a_credit_range: assert property (@(posedge clk) disable iff (!reset_n)
    credits <= CW'(RSP_QUEUE));

endmodule

// File: rtl/tex_mem_responder.sv
// Texture memory responder: round-robin arbiter onto a byte-enabled single-port RAM with
// fixed-latency read returns into per-channel credited response lanes.
module tex_mem_responder
  import tex_mem_responder_pkg::*;
#(
  parameter int NUM_REQS   = TEX_MEM_NUM_REQS_DEFAULT,
  parameter int ADDR_WIDTH = TEX_MEM_ADDR_WIDTH_DEFAULT,
  parameter int TAG_WIDTH  = TEX_MEM_TAG_WIDTH_DEFAULT,
  parameter int LATENCY    = TEX_MEM_LATENCY_DEFAULT,
  parameter int RSP_QUEUE  = TEX_MEM_RSP_QUEUE_DEFAULT
) (
  input logic                clk,
  input logic                reset_n,
  tex_mem_responder_if.slave bus
);
  localparam int PTR_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int DATA_W = TEX_MEM_DATA_W;

  logic [ADDR_WIDTH-1:0] addr_ch   [NUM_REQS];
  logic [DATA_W-1:0]     wdata_ch  [NUM_REQS];
  logic [3:0]            byteen_ch [NUM_REQS];
  logic [TAG_WIDTH-1:0]  tag_ch    [NUM_REQS];

  logic [NUM_REQS-1:0] credit_avail, eligible, push, take;
  logic                active, grant_found, rd_fire, wr_fire;
  logic [PTR_W-1:0]    rr_ptr, rr_next, grant_idx, cand;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [3:0]            sel_byteen;
  logic [TAG_WIDTH-1:0]  sel_tag;

  logic [DATA_W-1:0]     mem    [2**ADDR_WIDTH];
  logic [LATENCY-1:0]    vld_p;
  logic [PTR_W-1:0]      chan_p [LATENCY];
  logic [TAG_WIDTH-1:0]  tag_p  [LATENCY];
  logic [DATA_W-1:0]     data_p [LATENCY];

  assign eligible = bus.req_valid & (bus.req_rw | credit_avail);

  // Scan from the pointer downward in priority so the first eligible channel at or after it wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    cand        = rr_ptr;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQS);
      if (eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (active && grant_found) bus.req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_next = rr_ptr;
    if (active && grant_found)
      rr_next = (grant_idx == PTR_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
  end

  // active holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      rr_ptr <= '0;
    end else begin
      active <= 1'b1;
      rr_ptr <= rr_next;
    end
  end

  assign sel_addr   = addr_ch[grant_idx];
  assign sel_wdata  = wdata_ch[grant_idx];
  assign sel_byteen = byteen_ch[grant_idx];
  assign sel_tag    = tag_ch[grant_idx];
  assign wr_fire    = active && grant_found && bus.req_rw[grant_idx];
  assign rd_fire    = active && grant_found && !bus.req_rw[grant_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_fire;
      for (int s = 1; s < LATENCY; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  // stage p0: RAM write/read; stages p1..p(LATENCY-1): return delay
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++)
        if (sel_byteen[b]) mem[sel_addr][8*b +: 8] <= sel_wdata[8*b +: 8];
    end
    data_p[0] <= mem[sel_addr];
    tag_p[0]  <= sel_tag;
    chan_p[0] <= grant_idx;
    for (int s = 1; s < LATENCY; s++) begin
      data_p[s] <= data_p[s-1];
      tag_p[s]  <= tag_p[s-1];
      chan_p[s] <= chan_p[s-1];
    end
  end

  // stage p(LATENCY-1) -> lane queue
  always_comb begin
    push = '0;
    take = '0;
    push[chan_p[LATENCY-1]] = vld_p[LATENCY-1];
    take[grant_idx]         = rd_fire;
  end

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    logic                 lane_valid;
    logic [TAG_WIDTH-1:0] lane_tag;
    logic [DATA_W-1:0]    lane_data;

    assign addr_ch[i]   = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_ch[i]  = bus.req_data[i*DATA_W +: DATA_W];
    assign byteen_ch[i] = bus.req_byteen[i*4 +: 4];
    assign tag_ch[i]    = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];

    tex_mem_rsp_lane #(
      .TAG_WIDTH (TAG_WIDTH),
      .RSP_QUEUE (RSP_QUEUE)
    ) u_lane (
      .clk          (clk),
      .reset_n      (reset_n),
      .take         (take[i]),
      .push         (push[i]),
      .push_tag     (tag_p[LATENCY-1]),
      .push_data    (data_p[LATENCY-1]),
      .credit_avail (credit_avail[i]),
      .rsp_valid    (lane_valid),
      .rsp_tag      (lane_tag),
      .rsp_data     (lane_data),
      .rsp_ready    (bus.rsp_ready[i])
    );

    assign bus.rsp_valid[i]                       = lane_valid;
    assign bus.rsp_tag[i*TAG_WIDTH +: TAG_WIDTH] = lane_tag;
    assign bus.rsp_data[i*DATA_W +: DATA_W]      = lane_data;
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(bus.req_ready));

endmodule

// File: tb/tb_tex_mem_responder.sv
// Scoreboard bench for tex_mem_responder: request queues feed a driver, accepted reads push
// expected responses, and a monitor pops and compares every response handshake.
module tb_tex_mem_responder;
  import tex_mem_responder_pkg::*;

  localparam int NR  = 4;
  localparam int AW  = 12;
  localparam int TW  = 8;
  localparam int LAT = 2;
  localparam int RQ  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tex_mem_responder_if #(.NUM_REQS(NR), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

  tex_mem_responder #(
    .NUM_REQS(NR), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .LATENCY(LAT), .RSP_QUEUE(RQ)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic          rw;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [TW-1:0] tag;
    bit            chk;
    logic [31:0]   exp;
  } req_t;

  req_t         req_q [NR][$];
  tex_mem_rsp_t exp_q [NR][$];
  logic [31:0]  model [2**AW];
  int checks = 0, failures = 0, cyc = 0;
  int acc_cnt [NR], rsp_cnt [NR], fire_cyc [NR], rsp_cyc [NR], rdy_mode [NR];
  bit log_en = 1'b0;
  int grant_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic req_t mk(bit rw, logic [3:0] be, logic [AW-1:0] a, logic [31:0] d,
                              logic [TW-1:0] t, bit chk, logic [31:0] exp);
    req_t r;
    r.rw = rw; r.be = be; r.addr = a; r.data = d; r.tag = t; r.chk = chk; r.exp = exp;
    return r;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit idle();
    for (int c = 0; c < NR; c++)
      if (req_q[c].size() != 0 || exp_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Driver: present the head of each channel's request queue; rsp_ready per mode.
  initial begin
    bus.req_valid = '0; bus.req_rw = '0; bus.req_byteen = '0; bus.req_addr = '0;
    bus.req_data = '0; bus.req_tag = '0; bus.rsp_ready = '0;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < NR; c++) begin
        if (req_q[c].size() != 0) begin
          bus.req_valid[c]         = 1'b1;
          bus.req_rw[c]            = req_q[c][0].rw;
          bus.req_byteen[c*4 +: 4] = req_q[c][0].be;
          bus.req_addr[c*AW +: AW] = req_q[c][0].addr;
          bus.req_data[c*32 +: 32] = req_q[c][0].data;
          bus.req_tag[c*TW +: TW]  = req_q[c][0].tag;
        end else begin
          bus.req_valid[c] = 1'b0;
        end
        case (rdy_mode[c])
          0:       bus.rsp_ready[c] = 1'b0;
          1:       bus.rsp_ready[c] = 1'b1;
          default: bus.rsp_ready[c] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // Acceptance tracker: apply writes to the model, turn reads into expected responses.
  always @(negedge clk) begin : acc
    req_t h;
    tex_mem_rsp_t e;
    if (reset_n) begin
      check("req_ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
      for (int c = 0; c < NR; c++) begin
        if (bus.req_valid[c] && bus.req_ready[c]) begin
          h = req_q[c].pop_front();
          acc_cnt[c]++;
          if (log_en) grant_log.push_back(c);
          if (h.rw) begin
            model[h.addr] = merge(model[h.addr], h.data, h.be);
          end else begin
            e.tag  = h.tag;
            e.data = h.chk ? h.exp : model[h.addr];
            exp_q[c].push_back(e);
            fire_cyc[c] = cyc;
          end
        end
      end
    end
  end

  // Monitor: every response handshake is compared against the channel's expected queue.
  always @(negedge clk) begin : mon
    tex_mem_rsp_t e;
    if (reset_n) begin
      for (int c = 0; c < NR; c++) begin
        if (bus.rsp_valid[c] && bus.rsp_ready[c]) begin
          rsp_cnt[c]++;
          rsp_cyc[c] = cyc;
          if (exp_q[c].size() == 0) begin
            check($sformatf("rsp_unexpected ch%0d", c), 64'd1, 64'd0);
          end else begin
            e = exp_q[c].pop_front();
            check($sformatf("rsp_tag ch%0d", c), bus.rsp_tag[c*TW +: TW], e.tag);
            check($sformatf("rsp_data ch%0d", c), bus.rsp_data[c*32 +: 32], e.data);
          end
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!idle() && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (!idle()) check("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin : main
    int base [NR];
    int rbase, any_valid, n, reads;
    for (int c = 0; c < NR; c++) begin
      rdy_mode[c] = 1; acc_cnt[c] = 0; rsp_cnt[c] = 0; fire_cyc[c] = 0; rsp_cyc[c] = 0;
    end

    // Reset: a pending write must not be accepted while reset is held.
    req_q[0].push_back(mk(1, 4'hF, 12'h010, 32'hA5A5_1234, 8'h00, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rsp_valid", bus.rsp_valid, 64'h0);
    check("reset req_ready", bus.req_ready, 64'h0);
    @(posedge clk); #2 reset_n = 1'b1;

    // Single write then read with latency check.
    req_q[0].push_back(mk(0, 4'h0, 12'h010, 32'h0, 8'h3C, 1, 32'hA5A5_1234));
    wait_drain(50);
    check("read latency", 64'(rsp_cyc[0] - fire_cyc[0]), 64'(LAT + 1));
    check("ch0 rsp count", 64'(rsp_cnt[0]), 64'd1);

    // Byte enables.
    req_q[1].push_back(mk(1, 4'hF, 12'h020, 32'hFFFF_FFFF, 8'h00, 0, 0));
    req_q[1].push_back(mk(1, 4'h5, 12'h020, 32'h1122_3344, 8'h00, 0, 0));
    req_q[1].push_back(mk(0, 4'h0, 12'h020, 32'h0, 8'h41, 1, 32'hFF22_FF44));
    wait_drain(50);

    // Fairness: last grant was ch1, so rotation starts at ch2.
    grant_log.delete();
    log_en = 1'b1;
    for (int c = 0; c < NR; c++)
      for (int k = 0; k < 4; k++)
        req_q[c].push_back(mk(0, 4'h0, (k % 2) ? 12'h020 : 12'h010, 32'h0, 8'(16*c + k), 0, 0));
    wait_drain(100);
    log_en = 1'b0;
    check("fair grant count", 64'(grant_log.size()), 64'd16);
    n = 0;
    for (int i = 0; i < grant_log.size(); i++) if (grant_log[i] != (2 + i) % 4) n++;
    check("fair rr order errors", 64'(n), 64'd0);

    // Backpressure on ch2 while the others keep flowing.
    for (int c = 0; c < NR; c++) base[c] = acc_cnt[c];
    rbase = rsp_cnt[2];
    rdy_mode[2] = 0;
    for (int k = 0; k < 6; k++) req_q[2].push_back(mk(0, 4'h0, 12'h020, 32'h0, 8'(8'h80 + k), 0, 0));
    for (int c = 0; c < NR; c++)
      if (c != 2)
        for (int k = 0; k < 8; k++)
          req_q[c].push_back(mk(0, 4'h0, (k % 2) ? 12'h010 : 12'h020, 32'h0, 8'(8'h20 + k), 0, 0));
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("bp ch2 accepted", 64'(acc_cnt[2] - base[2]), 64'd4);
    check("bp req_ready[2]", 64'(bus.req_ready[2]), 64'd0);
    check("bp ch0 accepted", 64'(acc_cnt[0] - base[0]), 64'd8);
    check("bp ch1 accepted", 64'(acc_cnt[1] - base[1]), 64'd8);
    check("bp ch3 accepted", 64'(acc_cnt[3] - base[3]), 64'd8);
    rdy_mode[2] = 1;
    wait_drain(200);
    check("bp ch2 responses", 64'(rsp_cnt[2] - rbase), 64'd6);

    // Reset mid-flight: three reads in pipeline/queues are discarded.
    for (int c = 0; c < 3; c++) rdy_mode[c] = 0;
    n = acc_cnt[0] + acc_cnt[1] + acc_cnt[2];
    for (int c = 0; c < 3; c++) req_q[c].push_back(mk(0, 4'h0, 12'h010, 32'h0, 8'(8'hD0 + c), 0, 0));
    for (int w = 0; w < 20 && (acc_cnt[0] + acc_cnt[1] + acc_cnt[2]) < n + 3; w++) @(posedge clk);
    check("midflight accepted", 64'(acc_cnt[0] + acc_cnt[1] + acc_cnt[2] - n), 64'd3);
    @(posedge clk); #2 reset_n = 1'b0;
    for (int c = 0; c < NR; c++) exp_q[c].delete();
    @(posedge clk); #2 reset_n = 1'b1;
    for (int c = 0; c < NR; c++) rdy_mode[c] = 1;
    any_valid = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) any_valid = 1;
    end
    check("post-reset rsp_valid", 64'(any_valid), 64'd0);
    rdy_mode[0] = 0;
    base[0] = acc_cnt[0];
    rbase = rsp_cnt[0];
    for (int k = 0; k < 6; k++) req_q[0].push_back(mk(0, 4'h0, 12'h010, 32'h0, 8'(8'hE0 + k), 0, 0));
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post-reset credits", 64'(acc_cnt[0] - base[0]), 64'd4);
    rdy_mode[0] = 1;
    wait_drain(200);
    check("post-reset responses", 64'(rsp_cnt[0] - rbase), 64'd6);

    // Random soak over a small address window.
    for (int k = 0; k < 16; k++) req_q[3].push_back(mk(1, 4'hF, 12'(12'h100 + k), $urandom, 8'h00, 0, 0));
    wait_drain(200);
    for (int c = 0; c < NR; c++) rdy_mode[c] = 2;
    rbase = rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3];
    reads = 0;
    for (int c = 0; c < NR; c++)
      for (int k = 0; k < 2500; k++) begin
        req_q[c].push_back(mk($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                              12'(12'h100 + $urandom_range(0, 15)), $urandom,
                              8'($urandom_range(0, 255)), 0, 0));
        if (!req_q[c][k].rw) reads++;
      end
    wait_drain(60000);
    check("soak response count", 64'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3] - rbase),
          64'(reads));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
